ahbl_sram64_ctrl: RTL and testbench
===================================

Name: ahbl_sram64_ctrl

Overview:
- AHB-Lite slave (responder) that bridges the 64-bit system bus to a single-port synchronous 64-bit SRAM macro (1024x64 class).
- Sits behind the bus decoder as a memory slave, serving the EL2 master.
- Zero-wait-state for every transfer, using a one-entry write buffer with read-merge forwarding.

Parameters:
- RAM_AW, 10, SRAM word-address width (depth = 2^RAM_AW 64-bit words).

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select from bus decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HREADY  in  1  bus-level ready; address phase is valid only when this is 1.
- HWDATA  in  64  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready; constant 1.
- HRESP  out  1  response; constant 0 (OKAY).
- HRDATA  out  64  read data.
- SRAMRDATA  in  64  SRAM read data, valid the cycle after a read strobe.
- SRAMWEN  out  8  per-byte write enables; bit i covers bits [8i+7:8i].
- SRAMWDATA  out  64  SRAM write data.
- SRAMCS0  out  1  SRAM enable.
- SRAMADDR  out  RAM_AW  SRAM word address.

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS[1]. IDLE/BUSY are ignored.
- Word address = HADDR[RAM_AW+2:3]. Upper address bits alias. Alignment is not checked.
- Byte mask (lanes by HADDR[2:0]):
  - HSIZE=0: 1 lane.
  - HSIZE=1: 2 lanes at HADDR[2:1].
  - HSIZE=2: 4 lanes at HADDR[2].
  - HSIZE>=3: 0xFF.
- Registered state:
  - dp_rd: read data phase pending.
  - dp_wr: write data phase pending.
  - dp_addr, dp_mask: captured at address phase.
  - buf_valid, buf_addr, buf_mask, buf_data: one-entry write buffer.
- SRAM port arbitration per cycle (combinational), in priority order:
  1. Read address phase accepted: SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR word address.
  2. Else buf_valid: SRAMCS0=1, SRAMWEN=buf_mask, SRAMADDR=buf_addr, SRAMWDATA=buf_data. Clear buf_valid at edge.
  3. Else dp_wr: SRAMCS0=1, SRAMWEN=dp_mask, SRAMADDR=dp_addr, SRAMWDATA=HWDATA.
  4. Else: SRAMCS0=0, SRAMWEN=0. SRAMADDR and SRAMWDATA are don't-care, driven 0.
- Write during a colliding read: if dp_wr and a read address phase occur in the same cycle, the write goes to the buffer at the edge (buf_valid=1, buf_addr/buf_mask from dp_*, buf_data=HWDATA).
- Buffer invariants:
  - buf_valid and dp_wr are never both 1 when the port is free. Any write address phase drains an existing buffer.
  - At most one write is ever pending.
  - The buffer persists across consecutive read address phases.
- Read latency: data returns in the data phase, one cycle after the address phase.
  - HRDATA = SRAMRDATA, with lanes overridden by buf_data where buf_valid & buf_addr==dp_addr & buf_mask[i].
  - The merge uses buffer state in the data-phase cycle. This covers a write immediately followed by a read of the same word.
  - HRDATA=0 when dp_rd=0.
- HREADYOUT=1 and HRESP=0 in all cycles. There are no wait states and no error responses.
- Reset (asynchronous, any time):
  - All registers clear. A buffered write is discarded and never reaches the SRAM.
  - Outputs during and after reset: HREADYOUT=1, HRESP=0, HRDATA=0.
  - SRAMCS0=0 and SRAMWEN=0 unless a new read address phase is presented.

Test Plan:
- Reset with HSEL=0 → HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS0=0, SRAMWEN=0x00.
- Dword write HADDR=0x18, HWDATA=0x1122334455667788, then IDLE → in the data phase SRAMCS0=1, SRAMWEN=0xFF, SRAMADDR=3. A later read of 0x18 returns 0x1122334455667788 one cycle after its address phase.
- Byte write HADDR=0x5, HSIZE=0, HWDATA[47:40]=0xAB → SRAMWEN=0x20. Halfword at 0x6 → 0xC0. Word at 0x4 → 0xF0.
- Word 0x40 preloaded with 0x0; write word HADDR=0x44 data 0xDEADBEEF, followed immediately by a dword read of 0x40:
  - Read strobe occurs in the write's data phase; the write is buffered.
  - HRDATA=0xDEADBEEF_00000000.
  - Buffer drains in the next non-read cycle with SRAMWEN=0xF0.
- Write 0x80, then four back-to-back reads of 0x100–0x118 → HREADYOUT stays 1, buffer is held throughout, and SRAMWEN=0x00 until the first idle cycle, when the 0x80 write issues.
- Write 0x80 followed by a read (buffer valid), then assert HRESETn=0 for one cycle → SRAMWEN never asserts for address 0x10. A subsequent read of 0x80 returns the old contents.

Source files
------------

// File: rtl/ahbl_sram64_ctrl.sv
// AHB-Lite slave bridging the 64-bit bus to a single-port synchronous 64-bit SRAM.
// Zero wait states: a write that collides with a read is parked in a one-entry buffer.
module ahbl_sram64_ctrl #(
  parameter int RAM_AW = 10
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [63:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [63:0]       HRDATA,
  input  logic [63:0]       SRAMRDATA,
  output logic [7:0]        SRAMWEN,
  output logic [63:0]       SRAMWDATA,
  output logic              SRAMCS0,
  output logic [RAM_AW-1:0] SRAMADDR
);

  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] addr);
    logic [7:0] m;
    m = 8'h00;
    case (size)
      3'd0:    m = 8'h01 << addr;
      3'd1:    m = 8'h03 << {addr[2:1], 1'b0};
      3'd2:    m = 8'h0F << {addr[2], 2'b00};
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  logic              accept_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [RAM_AW-1:0] haddr_word_s;
  logic              buf_drain_s;
  logic              buf_hit_s;
  logic              unused_s;

  logic              dp_rd_r;
  logic              dp_wr_r;
  logic [RAM_AW-1:0] dp_addr_r;
  logic [7:0]        dp_mask_r;
  logic              buf_valid_r;
  logic [RAM_AW-1:0] buf_addr_r;
  logic [7:0]        buf_mask_r;
  logic [63:0]       buf_data_r;

  assign accept_s     = HSEL & HREADY & HTRANS[1];
  assign rd_acc_s     = accept_s & ~HWRITE;
  assign wr_acc_s     = accept_s & HWRITE;
  assign haddr_word_s = HADDR[RAM_AW+2:3];
  assign buf_hit_s    = buf_valid_r && (buf_addr_r == dp_addr_r);
  assign unused_s     = ^{HADDR[31:RAM_AW+3], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // SRAM port arbitration: a new read beats the buffered write, which beats a direct write
  always_comb begin
    SRAMCS0     = 1'b0;
    SRAMWEN     = 8'h00;
    SRAMADDR    = {RAM_AW{1'b0}};
    SRAMWDATA   = 64'h0;
    buf_drain_s = 1'b0;
    if (rd_acc_s) begin
      SRAMCS0  = 1'b1;
      SRAMADDR = haddr_word_s;
    end else if (buf_valid_r) begin
      SRAMCS0     = 1'b1;
      SRAMWEN     = buf_mask_r;
      SRAMADDR    = buf_addr_r;
      SRAMWDATA   = buf_data_r;
      buf_drain_s = 1'b1;
    end else if (dp_wr_r) begin
      SRAMCS0   = 1'b1;
      SRAMWEN   = dp_mask_r;
      SRAMADDR  = dp_addr_r;
      SRAMWDATA = HWDATA;
    end else begin
      SRAMCS0 = 1'b0;
    end
  end

  // Read data phase: SRAM data with any pending buffered lanes of the same word forwarded
  always_comb begin
    HRDATA = 64'h0;
    if (dp_rd_r) begin
      for (int i = 0; i < 8; i++) begin
        HRDATA[8*i +: 8] = (buf_hit_s && buf_mask_r[i]) ? buf_data_r[8*i +: 8]
                                                         : SRAMRDATA[8*i +: 8];
      end
    end else begin
      HRDATA = 64'h0;
    end
  end

  // Address-phase capture for the following data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_rd_r   <= 1'b0;
      dp_wr_r   <= 1'b0;
      dp_addr_r <= {RAM_AW{1'b0}};
      dp_mask_r <= 8'h00;
    end else begin
      dp_rd_r <= rd_acc_s;
      dp_wr_r <= wr_acc_s;
      if (accept_s) begin
        dp_addr_r <= haddr_word_s;
        dp_mask_r <= lane_mask(HSIZE, HADDR[2:0]);
      end
    end
  end

  // Write buffer: filled when a write data phase loses the port to a read, drained when the port frees
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= {RAM_AW{1'b0}};
      buf_mask_r  <= 8'h00;
      buf_data_r  <= 64'h0;
    end else if (dp_wr_r && rd_acc_s) begin
      buf_valid_r <= 1'b1;
      buf_addr_r  <= dp_addr_r;
      buf_mask_r  <= dp_mask_r;
      buf_data_r  <= HWDATA;
    end else if (buf_drain_s) begin
      buf_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahbl_sram64_ctrl.sv
// Scoreboard bench for ahbl_sram64_ctrl: directed AHB transfers against a behavioural SRAM.
module tb_ahbl_sram64_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [63:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic [63:0] SRAMRDATA;
  logic [7:0]  SRAMWEN;
  logic [63:0] SRAMWDATA;
  logic        SRAMCS0;
  logic [9:0]  SRAMADDR;

  typedef struct packed {
    logic [9:0]  addr;
    logic [7:0]  wen;
    logic [63:0] data;
  } wr_exp_t;

  logic [63:0] rd_q[$];
  wr_exp_t     wr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] next_wdata = 64'h0;
  logic        tb_dp_rd;
  logic [63:0] mem [0:1023];
  logic        mem_init = 1'b0;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDEF;

  ahbl_sram64_ctrl #(.RAM_AW(10)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMCS0(SRAMCS0), .SRAMADDR(SRAMADDR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural synchronous SRAM; words 32..35 preloaded with a recognisable pattern
  always @(posedge HCLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i >= 32 && i < 36) ? (64'hA0A0_0000_0000_0000 | 64'(i)) : 64'h0;
      SRAMRDATA <= 64'h0;
      mem_init  <= 1'b1;
    end else if (SRAMCS0) begin
      if (SRAMWEN == 8'h00) SRAMRDATA <= mem[SRAMADDR];
      else
        for (int b = 0; b < 8; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tb_dp_rd <= 1'b0;
    else          tb_dp_rd <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or an SRAM write
  always @(negedge HCLK) begin
    wr_exp_t w;
    logic [63:0] e;
    check("hreadyout", 64'(HREADYOUT), 64'h1);
    check("hresp", 64'(HRESP), 64'h0);
    if (tb_dp_rd) begin
      check("rd_expected", 64'(rd_q.size() > 0), 64'h1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("hrdata", HRDATA, e);
      end
    end
    if (SRAMWEN != 8'h00) begin
      check("wr_expected", 64'(wr_q.size() > 0), 64'h1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("wr_cs", 64'(SRAMCS0), 64'h1);
        check("wr_addr", 64'(SRAMADDR), 64'(w.addr));
        check("wr_wen", 64'(SRAMWEN), 64'(w.wen));
        check("wr_data", SRAMWDATA, w.data);
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [63:0] wd);
    HSEL       = v;
    HTRANS     = v ? 2'b10 : 2'b00;
    HWRITE     = w;
    HADDR      = a;
    HSIZE      = sz;
    HWDATA     = next_wdata;
    next_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] exp, input logic push);
    drive(1'b1, 1'b0, a, 3'd3, 64'h0);
    if (push) rd_q.push_back(exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd,
                    input logic [9:0] waddr, input logic [7:0] wen, input logic push);
    wr_exp_t w;
    drive(1'b1, 1'b1, a, sz, wd);
    w.addr = waddr; w.wen = wen; w.data = wd;
    if (push) wr_q.push_back(w);
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    idle();
    repeat (2) tick();
    #2;
    check("rst_hreadyout", 64'(HREADYOUT), 64'h1);
    check("rst_hresp", 64'(HRESP), 64'h0);
    check("rst_hrdata", HRDATA, 64'h0);
    check("rst_cs", 64'(SRAMCS0), 64'h0);
    check("rst_wen", 64'(SRAMWEN), 64'h0);
    HRESETn = 1'b1;
    tick();

    // dword write then read back
    wr(32'h18, 3'd3, D1, 10'd3, 8'hFF, 1'b1); tick();
    idle(); #2;
    check("dw_cs", 64'(SRAMCS0), 64'h1);
    check("dw_wen", 64'(SRAMWEN), 64'hFF);
    check("dw_addr", 64'(SRAMADDR), 64'h3);
    tick();
    rd(32'h18, D1, 1'b1); tick();
    idle(); tick(); idle(); tick();

    // sub-word lane masks into word 0
    wr(32'h4, 3'd2, 64'h1234_5678_0000_0000, 10'd0, 8'hF0, 1'b1); tick();
    wr(32'h5, 3'd0, 64'h0000_AB00_0000_0000, 10'd0, 8'h20, 1'b1); tick();
    wr(32'h6, 3'd1, 64'hCDEF_0000_0000_0000, 10'd0, 8'hC0, 1'b1); tick();
    wr(32'h1, 3'd0, 64'h0000_0000_0000_5A00, 10'd0, 8'h02, 1'b1); tick();
    idle(); tick();
    rd(32'h0, 64'hCDEF_AB78_0000_5A00, 1'b1); tick();
    idle(); tick(); idle(); tick();

    // write immediately followed by read of the same word
    wr(32'h44, 3'd2, 64'hDEAD_BEEF_0000_0000, 10'd8, 8'hF0, 1'b1); tick();
    rd(32'h40, 64'hDEAD_BEEF_0000_0000, 1'b1); #2;
    check("col_rd_cs", 64'(SRAMCS0), 64'h1);
    check("col_rd_wen", 64'(SRAMWEN), 64'h0);
    check("col_rd_addr", 64'(SRAMADDR), 64'h8);
    tick();
    idle(); #2;
    check("col_drain_wen", 64'(SRAMWEN), 64'hF0);
    tick();
    idle(); tick();

    // buffer held across back-to-back reads
    wr(32'h80, 3'd3, D5, 10'd16, 8'hFF, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      rd(32'h100 + 32'(8 * i), 64'hA0A0_0000_0000_0020 + 64'(i), 1'b1); #2;
      check("hold_wen", 64'(SRAMWEN), 64'h0);
      tick();
    end
    idle(); #2;
    check("hold_drain_wen", 64'(SRAMWEN), 64'hFF);
    check("hold_drain_addr", 64'(SRAMADDR), 64'h10);
    tick();
    idle(); tick();

    // reset discards a buffered write
    wr(32'h80, 3'd3, 64'hFFFF_0000_FFFF_0000, 10'd16, 8'hFF, 1'b0); tick();
    rd(32'h200, 64'h0, 1'b0); tick();
    HRESETn = 1'b0;
    idle(); #2;
    check("rst2_hrdata", HRDATA, 64'h0);
    check("rst2_cs", 64'(SRAMCS0), 64'h0);
    check("rst2_wen", 64'(SRAMWEN), 64'h0);
    tick();
    HRESETn = 1'b1;
    idle(); tick(); idle(); tick();
    rd(32'h80, D5, 1'b1); tick();
    idle(); tick(); idle(); tick();

    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    check("wr_q_drained", 64'(wr_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
